// File: rtl/sound_frame_sequencer.sv
// Frame sequencer for the sound unit: divides I_CLK down to 512 Hz steps
// and emits the 256/128/64 Hz length, sweep and envelope ticks.
module sound_frame_sequencer #(
   parameter int unsigned CLKS_PER_STEP = 64453
) (
   input  logic       I_CLK,
   input  logic       I_RESET_L,
   input  logic       I_MASTER_EN,
   input  logic       I_STEP_FORCE,
   output logic       O_LEN_TICK,
   output logic       O_SWEEP_TICK,
   output logic       O_ENV_TICK,
   output logic [2:0] O_STEP
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [19:0] DIV_LAST = 20'(CLKS_PER_STEP - 1);

   state_t      state;
   logic [19:0] divider;
   logic        step_event;

   // A forced step and a natural wrap collapse into one event.
   assign step_event = (state == RUN) && I_MASTER_EN &&
                       (I_STEP_FORCE || (divider == DIV_LAST));

   always_ff @(posedge I_CLK or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         state        <= IDLE;
         divider      <= '0;
         O_STEP       <= '0;
         O_LEN_TICK   <= 1'b0;
         O_SWEEP_TICK <= 1'b0;
         O_ENV_TICK   <= 1'b0;
      end else begin
         O_LEN_TICK   <= 1'b0;
         O_SWEEP_TICK <= 1'b0;
         O_ENV_TICK   <= 1'b0;
         case (state)
            IDLE: begin
               divider <= '0;
               O_STEP  <= '0;
               if (I_MASTER_EN) state <= RUN;
            end
            RUN: begin
               if (!I_MASTER_EN) begin
                  state   <= IDLE;
                  divider <= '0;
                  O_STEP  <= '0;
               end else if (step_event) begin
                  divider      <= '0;
                  O_STEP       <= O_STEP + 3'd1;
                  O_LEN_TICK   <= ~O_STEP[0];
                  O_SWEEP_TICK <= (O_STEP[1:0] == 2'd2);
                  O_ENV_TICK   <= (O_STEP == 3'd7);
               end else begin
                  divider <= divider + 20'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Self-checking bench for sound_frame_sequencer with a short step period:
// directed frame/force/disable/reset scenarios, then randomized traffic.
module tb_sound_frame_sequencer;

   localparam int unsigned N = 4;
   // Which steps raise each tick, indexed by the executed step number.
   localparam bit [7:0] LEN_STEPS   = 8'b0101_0101;
   localparam bit [7:0] SWEEP_STEPS = 8'b0100_0100;
   localparam bit [7:0] ENV_STEPS   = 8'b1000_0000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       frc;
   logic       len_tick;
   logic       sweep_tick;
   logic       env_tick;
   logic [2:0] step;

   int n_checks = 0;
   int n_errors = 0;

   bit m_run;
   int m_phase;
   int m_step;
   bit e_len, e_sweep, e_env;

   int cyc_no, n_len, n_sweep, n_env, first_len, first_sweep, last_env;

   sound_frame_sequencer #(.CLKS_PER_STEP(N)) dut (
      .I_CLK        (clk),
      .I_RESET_L    (rst_n),
      .I_MASTER_EN  (en),
      .I_STEP_FORCE (frc),
      .O_LEN_TICK   (len_tick),
      .O_SWEEP_TICK (sweep_tick),
      .O_ENV_TICK   (env_tick),
      .O_STEP       (step)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_phase = 0; m_step = 0;
      e_len = 0; e_sweep = 0; e_env = 0;
   endtask

   // Reference: m_phase counts cycles spent in the current step period.
   task automatic model_edge();
      e_len = 0; e_sweep = 0; e_env = 0;
      if (!en) begin
         m_run = 0; m_phase = 0; m_step = 0;
      end else if (!m_run) begin
         m_run = 1; m_phase = 0; m_step = 0;
      end else if (frc || m_phase == N - 1) begin
         e_len   = LEN_STEPS[m_step];
         e_sweep = SWEEP_STEPS[m_step];
         e_env   = ENV_STEPS[m_step];
         m_step  = (m_step + 1) % 8;
         m_phase = 0;
      end else begin
         m_phase++;
      end
   endtask

   task automatic clear_counts();
      cyc_no = -1; n_len = 0; n_sweep = 0; n_env = 0;
      first_len = -1; first_sweep = -1; last_env = -1;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      cyc_no++;
      #1;
      check("len_tick", len_tick, e_len);
      check("sweep_tick", sweep_tick, e_sweep);
      check("env_tick", env_tick, e_env);
      check("step", step, m_step);
      if (len_tick) begin n_len++; if (first_len < 0) first_len = cyc_no; end
      if (sweep_tick) begin n_sweep++; if (first_sweep < 0) first_sweep = cyc_no; end
      if (env_tick) begin n_env++; last_env = cyc_no; end
   endtask

   task automatic run_until(input int s, input int ph);
      int guard = 0;
      while (!(m_step == s && (ph < 0 || m_phase == ph)) && guard < 200) begin
         cyc();
         guard++;
      end
      if (guard >= 200) check("run_until_timeout", 0, 1);
   endtask

   // Assert reset between edges and confirm outputs clear without a clock.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_len", len_tick, 0);
      check("rst_sweep", sweep_tick, 0);
      check("rst_env", env_tick, 0);
      check("rst_step", step, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; frc = 1'b0;
      model_reset();
      #3;
      check("reset_len", len_tick, 0);
      check("reset_sweep", sweep_tick, 0);
      check("reset_env", env_tick, 0);
      check("reset_step", step, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc();

      // Startup and one full frame.
      clear_counts();
      en = 1'b1;
      repeat (5) cyc();
      check("start_first_len", first_len, 4);
      check("start_step", step, 1);
      check("start_no_sweep", n_sweep, 0);
      check("start_no_env", n_env, 0);
      repeat (28) cyc();
      check("frame_len_count", n_len, 4);
      check("frame_sweep_count", n_sweep, 2);
      check("frame_first_sweep", first_sweep, 12);
      check("frame_env_count", n_env, 1);
      check("frame_env_cycle", last_env, 32);
      check("frame_step_wrap", step, 0);

      // Forced step at divider=1, step=2.
      run_until(2, 1);
      frc = 1'b1; cyc(); frc = 1'b0;
      check("force_len", len_tick, 1);
      check("force_sweep", sweep_tick, 1);
      check("force_step", step, 3);
      // Force coincident with natural wrap: single advance, divider restarts.
      run_until(3, 3);
      frc = 1'b1; cyc(); frc = 1'b0;
      check("coinc_step", step, 4);
      repeat (3) cyc();
      check("coinc_hold_step", step, 4);
      cyc();
      check("coinc_next_step", step, 5);
      check("coinc_next_len", len_tick, 1);

      // Master disable at step 5, idle, then re-enable.
      run_until(5, -1);
      en = 1'b0; cyc();
      check("dis_step", step, 0);
      clear_counts();
      frc = 1'b1;
      repeat (20) cyc();
      frc = 1'b0;
      check("dis_no_ticks", n_len + n_sweep + n_env, 0);
      clear_counts();
      en = 1'b1;
      repeat (5) cyc();
      check("reen_first_len", first_len, 4);
      check("reen_step", step, 1);

      // Asynchronous reset mid-frame at step 6.
      run_until(6, -1);
      do_reset();
      clear_counts();
      repeat (5) cyc();
      check("post_rst_first_len", first_len, 4);
      check("post_rst_step", step, 1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         en  = ($urandom_range(0, 99) < 97);
         frc = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
